// File: rtl/rs_multi_issue.sv
// Multi-lane reservation station: dispatch up to DISPATCH_W ops per cycle, snoop CDB_W broadcast
// channels for operand wakeup, issue up to ISSUE_W ready ops per cycle oldest-first.
module rs_multi_issue #(
   parameter int SIZE       = 32,
   parameter int ALUOP_BITS = 3,
   parameter int TAG_BITS   = 4,
   parameter int ENTRIES    = 8,
   parameter int DISPATCH_W = 2,
   parameter int ISSUE_W    = 2,
   parameter int CDB_W      = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   flush,
   input  logic [DISPATCH_W-1:0]                  disp_valid,
   input  logic [DISPATCH_W-1:0][ALUOP_BITS-1:0]  disp_aluop,
   input  logic [DISPATCH_W-1:0][TAG_BITS-1:0]    disp_src1_tag,
   input  logic [DISPATCH_W-1:0][TAG_BITS-1:0]    disp_src2_tag,
   input  logic [DISPATCH_W-1:0]                  disp_src1_rdy,
   input  logic [DISPATCH_W-1:0]                  disp_src2_rdy,
   input  logic [DISPATCH_W-1:0][SIZE-1:0]        disp_src1_val,
   input  logic [DISPATCH_W-1:0][SIZE-1:0]        disp_src2_val,
   input  logic [DISPATCH_W-1:0]                  disp_use_imm,
   input  logic [DISPATCH_W-1:0][SIZE-1:0]        disp_imm,
   input  logic [DISPATCH_W-1:0][TAG_BITS-1:0]    disp_dest_tag,
   output logic                                   disp_accept,
   input  logic [CDB_W-1:0]                       cdb_valid,
   input  logic [CDB_W-1:0][TAG_BITS-1:0]         cdb_tag,
   input  logic [CDB_W-1:0][SIZE-1:0]             cdb_value,
   output logic [ISSUE_W-1:0]                     iss_valid,
   input  logic [ISSUE_W-1:0]                     iss_ready,
   output logic [ISSUE_W-1:0][ALUOP_BITS-1:0]     iss_aluop,
   output logic [ISSUE_W-1:0][SIZE-1:0]           iss_op1,
   output logic [ISSUE_W-1:0][SIZE-1:0]           iss_op2,
   output logic [ISSUE_W-1:0][TAG_BITS-1:0]       iss_dest_tag,
   output logic [$clog2(ENTRIES+1)-1:0]           occupancy
);

   localparam int CNT_W = $clog2(ENTRIES + 1);
   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(ENTRIES - DISPATCH_W);

   typedef struct packed {
      logic                  valid;
      logic [ALUOP_BITS-1:0] aluop;
      logic [TAG_BITS-1:0]   src1_tag;
      logic                  src1_rdy;
      logic [SIZE-1:0]       src1_val;
      logic [TAG_BITS-1:0]   src2_tag;
      logic                  src2_rdy;
      logic [SIZE-1:0]       src2_val;
      logic [TAG_BITS-1:0]   dest_tag;
   } entry_t;

   // older_q[i][j] = 1 when entry i was dispatched before entry j (both resident).
   entry_t [ENTRIES-1:0]              ent_q, ent_d;
   logic   [ENTRIES-1:0][ENTRIES-1:0] older_q, older_d;

   logic [ENTRIES-1:0]                ent_ready;
   logic [ENTRIES-1:0]                fire;
   logic [ENTRIES-1:0][CNT_W-1:0]     rank;
   logic [DISPATCH_W-1:0]             alloc_en;
   logic [DISPATCH_W-1:0][IDX_W-1:0]  alloc_idx;

   // Returns {rdy, val} after snooping the CDB; the lowest matching channel wins.
   function automatic logic [SIZE:0] wake(
      input logic [TAG_BITS-1:0]             tag,
      input logic                            rdy,
      input logic [SIZE-1:0]                 val,
      input logic [CDB_W-1:0]                cv,
      input logic [CDB_W-1:0][TAG_BITS-1:0]  ct,
      input logic [CDB_W-1:0][SIZE-1:0]      cx
   );
      logic [SIZE:0] res;
      res = {rdy, val};
      for (int c = CDB_W - 1; c >= 0; c--) begin
         if (!rdy && cv[c] && ct[c] == tag) res = {1'b1, cx[c]};
      end
      return res;
   endfunction

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < ENTRIES; i++) occupancy = occupancy + CNT_W'(ent_q[i].valid);
   end

   assign disp_accept = (occupancy <= ACC_MAX);

   // Issue handshake: port p offers an op whenever iss_valid[p]=1, independent of iss_ready;
   // the op leaves the station only on a cycle with iss_valid[p] & iss_ready[p].
   always_comb begin
      ent_ready    = '0;
      rank         = '0;
      fire         = '0;
      iss_valid    = '0;
      iss_aluop    = '0;
      iss_op1      = '0;
      iss_op2      = '0;
      iss_dest_tag = '0;
      for (int i = 0; i < ENTRIES; i++)
         ent_ready[i] = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
      for (int i = 0; i < ENTRIES; i++) begin
         for (int j = 0; j < ENTRIES; j++) begin
            if (ent_ready[j] && older_q[j][i]) rank[i] = rank[i] + CNT_W'(1);
         end
      end
      for (int p = 0; p < ISSUE_W; p++) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (ent_ready[i] && rank[i] == CNT_W'(p)) begin
               iss_valid[p]    = 1'b1;
               iss_aluop[p]    = ent_q[i].aluop;
               iss_op1[p]      = ent_q[i].src1_val;
               iss_op2[p]      = ent_q[i].src2_val;
               iss_dest_tag[p] = ent_q[i].dest_tag;
               fire[i]         = iss_ready[p];
            end
         end
      end
   end

   // Slots freed by this cycle's fires are still marked valid here, so they are not reused yet.
   always_comb begin
      logic [ENTRIES-1:0] taken;
      logic               found;
      taken     = '0;
      found     = 1'b0;
      alloc_en  = '0;
      alloc_idx = '0;
      for (int k = 0; k < DISPATCH_W; k++) begin
         if (disp_accept && disp_valid[k]) begin
            found = 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
               if (!found && !ent_q[i].valid && !taken[i]) begin
                  found        = 1'b1;
                  taken[i]     = 1'b1;
                  alloc_idx[k] = IDX_W'(i);
               end
            end
            alloc_en[k] = found;
         end
      end
   end

   always_comb begin
      entry_t nw;
      nw      = '0;
      ent_d   = ent_q;
      older_d = older_q;
      for (int i = 0; i < ENTRIES; i++) begin
         if (fire[i]) begin
            ent_d[i].valid = 1'b0;
            for (int j = 0; j < ENTRIES; j++) begin
               older_d[i][j] = 1'b0;
               older_d[j][i] = 1'b0;
            end
         end else if (ent_q[i].valid) begin
            {ent_d[i].src1_rdy, ent_d[i].src1_val} =
               wake(ent_q[i].src1_tag, ent_q[i].src1_rdy, ent_q[i].src1_val, cdb_valid, cdb_tag, cdb_value);
            {ent_d[i].src2_rdy, ent_d[i].src2_val} =
               wake(ent_q[i].src2_tag, ent_q[i].src2_rdy, ent_q[i].src2_val, cdb_valid, cdb_tag, cdb_value);
         end
      end
      for (int k = 0; k < DISPATCH_W; k++) begin
         if (alloc_en[k]) begin
            nw.valid    = 1'b1;
            nw.aluop    = disp_aluop[k];
            nw.src1_tag = disp_src1_tag[k];
            {nw.src1_rdy, nw.src1_val} =
               wake(disp_src1_tag[k], disp_src1_rdy[k], disp_src1_val[k], cdb_valid, cdb_tag, cdb_value);
            nw.src2_tag = disp_use_imm[k] ? '0 : disp_src2_tag[k];
            {nw.src2_rdy, nw.src2_val} = disp_use_imm[k] ? {1'b1, disp_imm[k]} :
               wake(disp_src2_tag[k], disp_src2_rdy[k], disp_src2_val[k], cdb_valid, cdb_tag, cdb_value);
            nw.dest_tag = disp_dest_tag[k];
            ent_d[alloc_idx[k]] = nw;
            // New entries are younger than every surviving resident and than earlier lanes.
            for (int j = 0; j < ENTRIES; j++) begin
               older_d[alloc_idx[k]][j] = 1'b0;
               older_d[j][alloc_idx[k]] = ent_q[j].valid & ~fire[j];
            end
            for (int m = 0; m < k; m++) begin
               if (alloc_en[m]) older_d[alloc_idx[m]][alloc_idx[k]] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q   <= '0;
         older_q <= '0;
      end else if (flush) begin
         ent_q   <= '0;
         older_q <= '0;
      end else begin
         ent_q   <= ent_d;
         older_q <= older_d;
      end
   end

endmodule

// File: tb/tb_rs_multi_issue.sv
// Bench for rs_multi_issue: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against an age-ordered queue model.
module tb_rs_multi_issue;

   localparam int SIZE    = 32;
   localparam int AB      = 3;
   localparam int TB      = 4;
   localparam int ENTRIES = 8;
   localparam int DW      = 2;
   localparam int IW      = 2;
   localparam int CW      = 2;
   localparam int OW      = $clog2(ENTRIES + 1);

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   flush;
   logic [DW-1:0]          disp_valid;
   logic [DW-1:0][AB-1:0]  disp_aluop;
   logic [DW-1:0][TB-1:0]  disp_src1_tag, disp_src2_tag;
   logic [DW-1:0]          disp_src1_rdy, disp_src2_rdy;
   logic [DW-1:0][SIZE-1:0] disp_src1_val, disp_src2_val;
   logic [DW-1:0]          disp_use_imm;
   logic [DW-1:0][SIZE-1:0] disp_imm;
   logic [DW-1:0][TB-1:0]  disp_dest_tag;
   logic                   disp_accept;
   logic [CW-1:0]          cdb_valid;
   logic [CW-1:0][TB-1:0]  cdb_tag;
   logic [CW-1:0][SIZE-1:0] cdb_value;
   logic [IW-1:0]          iss_valid, iss_ready;
   logic [IW-1:0][AB-1:0]  iss_aluop;
   logic [IW-1:0][SIZE-1:0] iss_op1, iss_op2;
   logic [IW-1:0][TB-1:0]  iss_dest_tag;
   logic [OW-1:0]          occupancy;

   always #5 clk = ~clk;

   rs_multi_issue #(
      .SIZE(SIZE), .ALUOP_BITS(AB), .TAG_BITS(TB), .ENTRIES(ENTRIES),
      .DISPATCH_W(DW), .ISSUE_W(IW), .CDB_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_aluop(disp_aluop),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
      .disp_use_imm(disp_use_imm), .disp_imm(disp_imm), .disp_dest_tag(disp_dest_tag),
      .disp_accept(disp_accept),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_aluop(iss_aluop),
      .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_dest_tag(iss_dest_tag),
      .occupancy(occupancy)
   );

   typedef struct packed {
      logic v; logic [AB-1:0] op;
      logic [TB-1:0] t1; logic r1; logic [SIZE-1:0] v1;
      logic [TB-1:0] t2; logic r2; logic [SIZE-1:0] v2;
      logic ie; logic [SIZE-1:0] imm; logic [TB-1:0] d;
   } lane_t;

   typedef struct packed {
      logic [AB-1:0] op; logic [SIZE-1:0] a; logic [SIZE-1:0] b; logic [TB-1:0] d;
   } iss_t;

   typedef struct {
      lane_t l0, l1;
      logic [CW-1:0] cv; logic [TB-1:0] ct0, ct1; logic [SIZE-1:0] cx0, cx1;
      logic [IW-1:0] rdy; logic fl;
      logic [OW-1:0] e_occ; logic e_acc; logic [IW-1:0] e_iv; iss_t e_p0, e_p1;
   } vec_t;

   typedef struct packed {
      logic [AB-1:0] op;
      logic [TB-1:0] t1; logic r1; logic [SIZE-1:0] v1;
      logic [TB-1:0] t2; logic r2; logic [SIZE-1:0] v2;
      logic [TB-1:0] d;
   } m_ent_t;

   localparam int PW = $bits(iss_t);

   int total = 0;
   int bad = 0;
   m_ent_t m_q[$];
   int m_sel[$];
   logic [PW-1:0] exp_q[$];

   function automatic lane_t ln(logic [AB-1:0] op, logic [TB-1:0] t1, logic r1, logic [SIZE-1:0] v1,
                                logic [TB-1:0] t2, logic r2, logic [SIZE-1:0] v2,
                                logic ie, logic [SIZE-1:0] imm, logic [TB-1:0] d);
      lane_t l;
      l = '{v: 1'b1, op: op, t1: t1, r1: r1, v1: v1, t2: t2, r2: r2, v2: v2, ie: ie, imm: imm, d: d};
      return l;
   endfunction

   function automatic iss_t pl(logic [AB-1:0] op, logic [SIZE-1:0] a, logic [SIZE-1:0] b, logic [TB-1:0] d);
      iss_t x;
      x = '{op: op, a: a, b: b, d: d};
      return x;
   endfunction

   // Op number n: src1 = n, immediate = 100+n, dest = n.
   function automatic lane_t nln(int n);
      return ln(AB'(n), '0, 1'b1, SIZE'(n), '0, 1'b0, '0, 1'b1, SIZE'(100 + n), TB'(n));
   endfunction

   function automatic iss_t npl(int n);
      return pl(AB'(n), SIZE'(n), SIZE'(100 + n), TB'(n));
   endfunction

   function automatic vec_t row(lane_t l0, lane_t l1, logic [CW-1:0] cv,
                                logic [TB-1:0] ct0, logic [SIZE-1:0] cx0,
                                logic [TB-1:0] ct1, logic [SIZE-1:0] cx1,
                                logic [IW-1:0] rdy, logic fl, logic [OW-1:0] occ, logic acc,
                                logic [IW-1:0] iv, iss_t p0, iss_t p1);
      vec_t r;
      r.l0 = l0; r.l1 = l1; r.cv = cv; r.ct0 = ct0; r.cx0 = cx0; r.ct1 = ct1; r.cx1 = cx1;
      r.rdy = rdy; r.fl = fl; r.e_occ = occ; r.e_acc = acc; r.e_iv = iv; r.e_p0 = p0; r.e_p1 = p1;
      return r;
   endfunction

   function automatic iss_t got_port(int p);
      return pl(iss_aluop[p], iss_op1[p], iss_op2[p], iss_dest_tag[p]);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic [OW-1:0] occ, input logic acc,
                          input logic [IW-1:0] iv, input iss_t p0, input iss_t p1);
      chk($sformatf("%s.occ", nm), occupancy, occ);
      chk($sformatf("%s.acc", nm), disp_accept, acc);
      chk($sformatf("%s.iv", nm), iss_valid, iv);
      chk($sformatf("%s.p0", nm), got_port(0), p0);
      chk($sformatf("%s.p1", nm), got_port(1), p1);
   endtask

   task automatic drive_lane(input int k, input lane_t l);
      disp_valid[k]    = l.v;
      disp_aluop[k]    = l.op;
      disp_src1_tag[k] = l.t1;
      disp_src1_rdy[k] = l.r1;
      disp_src1_val[k] = l.v1;
      disp_src2_tag[k] = l.t2;
      disp_src2_rdy[k] = l.r2;
      disp_src2_val[k] = l.v2;
      disp_use_imm[k]  = l.ie;
      disp_imm[k]      = l.imm;
      disp_dest_tag[k] = l.d;
   endtask

   task automatic idle_inputs();
      drive_lane(0, '0);
      drive_lane(1, '0);
      flush     = 1'b0;
      cdb_valid = '0;
      cdb_tag   = '0;
      cdb_value = '0;
      iss_ready = '0;
   endtask

   function automatic logic [SIZE:0] mwake(logic [TB-1:0] tag, logic r, logic [SIZE-1:0] v);
      if (r) return {r, v};
      for (int c = 0; c < CW; c++) begin
         if (cdb_valid[c] && cdb_tag[c] == tag) return {1'b1, cdb_value[c]};
      end
      return {r, v};
   endfunction

   // Expected outputs for the current state: ports show the first IW ready ops in age order.
   task automatic model_check();
      m_sel.delete();
      for (int i = 0; i < m_q.size(); i++) begin
         if (m_q[i].r1 && m_q[i].r2 && m_sel.size() < IW) m_sel.push_back(i);
      end
      chk("rnd.occ", occupancy, m_q.size());
      chk("rnd.acc", disp_accept, (ENTRIES - m_q.size()) >= DW);
      for (int p = 0; p < IW; p++) begin
         if (p < m_sel.size())
            exp_q.push_back(pl(m_q[m_sel[p]].op, m_q[m_sel[p]].v1, m_q[m_sel[p]].v2, m_q[m_sel[p]].d));
         else
            exp_q.push_back('0);
      end
      for (int p = 0; p < IW; p++) begin
         chk($sformatf("rnd.iv%0d", p), iss_valid[p], p < m_sel.size());
         chk($sformatf("rnd.port%0d", p), got_port(p), exp_q.pop_front());
      end
   endtask

   task automatic model_advance();
      m_ent_t nq[$];
      m_ent_t e;
      bit acc;
      bit fired;
      acc = (ENTRIES - m_q.size()) >= DW;
      if (flush) begin
         m_q.delete();
      end else begin
         for (int i = 0; i < m_q.size(); i++) begin
            fired = 1'b0;
            for (int p = 0; p < m_sel.size(); p++) begin
               if (m_sel[p] == i && iss_ready[p]) fired = 1'b1;
            end
            if (!fired) begin
               e = m_q[i];
               {e.r1, e.v1} = mwake(e.t1, e.r1, e.v1);
               {e.r2, e.v2} = mwake(e.t2, e.r2, e.v2);
               nq.push_back(e);
            end
         end
         if (acc) begin
            for (int k = 0; k < DW; k++) begin
               if (disp_valid[k]) begin
                  e.op = disp_aluop[k];
                  e.t1 = disp_src1_tag[k];
                  {e.r1, e.v1} = mwake(disp_src1_tag[k], disp_src1_rdy[k], disp_src1_val[k]);
                  e.t2 = disp_src2_tag[k];
                  if (disp_use_imm[k]) {e.r2, e.v2} = {1'b1, disp_imm[k]};
                  else {e.r2, e.v2} = mwake(disp_src2_tag[k], disp_src2_rdy[k], disp_src2_val[k]);
                  e.d = disp_dest_tag[k];
                  nq.push_back(e);
               end
            end
         end
         m_q = nq;
      end
   endtask

   initial begin
      vec_t  tbl[14];
      lane_t z, a0, a1, b0, b1, c0, d0;
      iss_t  p0;
      z  = '0;
      p0 = '0;
      a0 = ln(3'd0, 4'd0, 1'b1, 32'd5, 4'd5, 1'b0, 32'hFFFF, 1'b1, 32'd10, 4'd3);
      a1 = ln(3'd1, 4'd0, 1'b1, 32'd7, 4'd5, 1'b0, 32'hFFFF, 1'b1, 32'd1, 4'd4);
      b0 = ln(3'd2, 4'd6, 1'b0, 32'd0, 4'd0, 1'b1, 32'd1, 1'b0, 32'd0, 4'd7);
      b1 = ln(3'd3, 4'd6, 1'b0, 32'd0, 4'd0, 1'b1, 32'd2, 1'b0, 32'd0, 4'd8);
      c0 = ln(3'd4, 4'd9, 1'b0, 32'd0, 4'd10, 1'b0, 32'd0, 1'b0, 32'd0, 4'd1);
      d0 = ln(3'd5, 4'd9, 1'b1, 32'h55, 4'd0, 1'b1, 32'h66, 1'b0, 32'd0, 4'd2);
      tbl[0]  = row(z, z, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b00, p0, p0);
      tbl[1]  = row(a0, a1, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b00, p0, p0);
      tbl[2]  = row(z, z, 2'b00, 0, 0, 0, 0, 2'b11, 0, 2, 1, 2'b11, pl(0, 5, 10, 3), pl(1, 7, 1, 4));
      tbl[3]  = row(z, z, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b00, p0, p0);
      tbl[4]  = row(b0, z, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, p0, p0);
      tbl[5]  = row(b1, z, 2'b10, 6, 32'h0BAD, 6, 32'hDEAD, 2'b00, 0, 1, 1, 2'b00, p0, p0);
      tbl[6]  = row(z, z, 2'b00, 0, 0, 0, 0, 2'b11, 0, 2, 1, 2'b11,
                    pl(2, 32'hDEAD, 1, 7), pl(3, 32'hDEAD, 2, 8));
      tbl[7]  = row(z, z, 2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 1, 2'b00, p0, p0);
      tbl[8]  = row(c0, z, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, p0, p0);
      tbl[9]  = row(d0, z, 2'b11, 9, 32'h111, 9, 32'h222, 2'b00, 0, 1, 1, 2'b00, p0, p0);
      tbl[10] = row(z, z, 2'b10, 0, 0, 10, 32'h333, 2'b11, 0, 2, 1, 2'b01, pl(5, 32'h55, 32'h66, 2), p0);
      tbl[11] = row(z, z, 2'b00, 0, 0, 0, 0, 2'b10, 0, 1, 1, 2'b01, pl(4, 32'h111, 32'h333, 1), p0);
      tbl[12] = row(z, z, 2'b00, 0, 0, 0, 0, 2'b01, 0, 1, 1, 2'b01, pl(4, 32'h111, 32'h333, 1), p0);
      tbl[13] = row(z, z, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1, 2'b00, p0, p0);

      // Reset state.
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_out("reset", 0, 1, 2'b00, p0, p0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         drive_lane(0, tbl[i].l0);
         drive_lane(1, tbl[i].l1);
         cdb_valid    = tbl[i].cv;
         cdb_tag[0]   = tbl[i].ct0;
         cdb_value[0] = tbl[i].cx0;
         cdb_tag[1]   = tbl[i].ct1;
         cdb_value[1] = tbl[i].cx1;
         iss_ready    = tbl[i].rdy;
         flush        = tbl[i].fl;
         #1;
         chk_out($sformatf("vec%0d", i), tbl[i].e_occ, tbl[i].e_acc, tbl[i].e_iv, tbl[i].e_p0, tbl[i].e_p1);
         @(negedge clk);
      end

      // Fill all eight entries, then stall port 1 while port 0 drains in dispatch order.
      idle_inputs();
      for (int c = 0; c < 4; c++) begin
         drive_lane(0, nln(2 * c));
         drive_lane(1, nln(2 * c + 1));
         #1;
         chk_out($sformatf("fill%0d", c), OW'(2 * c), 1'b1, (c == 0) ? 2'b00 : 2'b11,
                 (c == 0) ? p0 : npl(0), (c == 0) ? p0 : npl(1));
         @(negedge clk);
      end
      idle_inputs();
      iss_ready = 2'b01;
      for (int s = 0; s < 3; s++) begin
         #1;
         chk_out($sformatf("stall%0d", s), OW'(8 - s), s >= 2, 2'b11, npl(s), npl(s + 1));
         @(negedge clk);
      end

      // Five resident; accept two more, then a full station must ignore the next group.
      iss_ready = 2'b00;
      drive_lane(0, nln(8));
      drive_lane(1, nln(9));
      #1;
      chk_out("bp_fill", 5, 1'b1, 2'b11, npl(3), npl(4));
      @(negedge clk);
      drive_lane(0, nln(10));
      drive_lane(1, nln(11));
      #1;
      chk_out("bp_full", 7, 1'b0, 2'b11, npl(3), npl(4));
      @(negedge clk);
      idle_inputs();
      iss_ready = 2'b11;
      for (int j = 0; j < 4; j++) begin
         #1;
         chk_out($sformatf("drain%0d", j), OW'(7 - 2 * j), (7 - 2 * j) <= 6, (j < 3) ? 2'b11 : 2'b01,
                 npl(3 + 2 * j), (j < 3) ? npl(4 + 2 * j) : p0);
         @(negedge clk);
      end
      #1;
      chk_out("drained", 0, 1'b1, 2'b00, p0, p0);
      @(negedge clk);

      // Flush with four resident ops and a dispatch group in the same cycle.
      iss_ready = 2'b00;
      for (int c = 0; c < 2; c++) begin
         drive_lane(0, nln(20 + 2 * c));
         drive_lane(1, nln(21 + 2 * c));
         @(negedge clk);
      end
      drive_lane(0, nln(24));
      drive_lane(1, nln(25));
      iss_ready = 2'b11;
      flush     = 1'b1;
      #1;
      chk_out("flush_cyc", 4, 1'b1, 2'b11, npl(20), npl(21));
      @(negedge clk);
      idle_inputs();
      iss_ready = 2'b11;
      for (int j = 0; j < 2; j++) begin
         #1;
         chk_out($sformatf("post_flush%0d", j), 0, 1'b1, 2'b00, p0, p0);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of a clock phase.
      iss_ready = 2'b00;
      drive_lane(0, nln(30));
      drive_lane(1, nln(31));
      @(negedge clk);
      idle_inputs();
      #1;
      chk_out("pre_rst", 2, 1'b1, 2'b11, npl(30), npl(31));
      #1;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 0, 1'b1, 2'b00, p0, p0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_out("post_rst", 0, 1'b1, 2'b00, p0, p0);
      @(negedge clk);

      // Randomized traffic against the queue model.
      m_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int k = 0; k < DW; k++) begin
            disp_valid[k]    = ($urandom_range(0, 9) < 6);
            disp_aluop[k]    = AB'($urandom);
            disp_src1_tag[k] = TB'($urandom_range(0, 5));
            disp_src2_tag[k] = TB'($urandom_range(0, 5));
            disp_src1_rdy[k] = $urandom_range(0, 1);
            disp_src2_rdy[k] = $urandom_range(0, 1);
            disp_src1_val[k] = $urandom;
            disp_src2_val[k] = $urandom;
            disp_use_imm[k]  = ($urandom_range(0, 3) == 0);
            disp_imm[k]      = $urandom;
            disp_dest_tag[k] = TB'($urandom);
         end
         for (int c = 0; c < CW; c++) begin
            cdb_valid[c] = $urandom_range(0, 1);
            cdb_tag[c]   = TB'($urandom_range(0, 5));
            cdb_value[c] = $urandom;
         end
         iss_ready = IW'($urandom);
         flush     = ($urandom_range(0, 39) == 0);
         #1;
         model_check();
         model_advance();
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rs_multi_issue.md
Name: rs_multi_issue

Overview:
- Parametrised successor to the two-row reservation station.
- Holds ENTRIES in-flight ALU ops: DISPATCH_W ops per cycle in, CDB_W common-data-bus channels snooped for operand wakeup, up to ISSUE_W ready ops per cycle out.
- Selection is oldest-first via an age matrix.
- Sits between rename/dispatch and the ALU/functional-unit ports; adds flush, FU backpressure and multi-channel CDB capture.

Parameters:
- SIZE, 32, operand/immediate/result width
- ALUOP_BITS, 3, opcode width
- TAG_BITS, 4, producer tag width
- ENTRIES, 8, station depth; must be >= DISPATCH_W and >= ISSUE_W
- DISPATCH_W, 2, dispatch lanes
- ISSUE_W, 2, issue ports
- CDB_W, 2, CDB broadcast channels

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of all entries
- disp_valid  in  [DISPATCH_W]  lane carries an op
- disp_aluop  in  [DISPATCH_W][ALUOP_BITS]  opcode
- disp_src1_tag, disp_src2_tag  in  [DISPATCH_W][TAG_BITS]  producer tags
- disp_src1_rdy, disp_src2_rdy  in  [DISPATCH_W]  operand value already valid
- disp_src1_val, disp_src2_val  in  [DISPATCH_W][SIZE]  operand values, meaningful when rdy=1
- disp_use_imm  in  [DISPATCH_W]  src2 replaced by immediate
- disp_imm  in  [DISPATCH_W][SIZE]  immediate
- disp_dest_tag  in  [DISPATCH_W][TAG_BITS]  result tag
- disp_accept  out  1  station accepts this cycle's dispatch group
- cdb_valid  in  [CDB_W]  broadcast valid
- cdb_tag  in  [CDB_W][TAG_BITS]  broadcast tag
- cdb_value  in  [CDB_W][SIZE]  broadcast value
- iss_valid  out  [ISSUE_W]  port holds an issuable op
- iss_ready  in  [ISSUE_W]  FU on port accepts
- iss_aluop  out  [ISSUE_W][ALUOP_BITS]  opcode
- iss_op1, iss_op2  out  [ISSUE_W][SIZE]  operands
- iss_dest_tag  out  [ISSUE_W][TAG_BITS]  result tag
- occupancy  out  $clog2(ENTRIES+1)  valid entry count

Behaviour:
- Entry state: valid, aluop, {tag, rdy, val} x2, dest_tag; age matrix older[i][j].
- Reset (async): all entries invalid, age matrix cleared. Outputs: iss_valid=0, iss payloads=0, occupancy=0, disp_accept=1.
- Dispatch:
  - disp_accept = (ENTRIES - occupancy) >= DISPATCH_W. Combinational from registered state; independent of disp_valid; entries freed this cycle are not counted.
  - All-or-nothing: lanes write only when disp_accept=1. Lanes with disp_valid=0 consume no entry.
  - Valid lanes fill the lowest free indices in lane order.
  - Lane k is older than lane k+1; all new entries are younger than every resident entry.
- use_imm: src2 rdy=1, val=disp_imm; disp_src2_* ignored.
- Wakeup:
  - Each cycle, every valid entry operand with rdy=0 compares its tag to each cdb_valid channel.
  - On match, at the edge: rdy<=1, val<=cdb_value. If several channels match, the lowest channel index wins.
  - The same compare applies to dispatching lanes in the same cycle (dispatch/CDB bypass), so no broadcast is lost.
- Ready entry: valid and both rdy=1. Wakeup-to-issue latency is 1 cycle; dispatch-to-issue minimum is 1 cycle; no same-cycle issue of a dispatching op.
- Select (combinational from registered state):
  - Port p presents the (p+1)-th oldest ready entry; iss_valid[p]=0 if fewer than p+1 ready entries exist.
  - Payload is zero when iss_valid=0.
  - iss_valid does not depend on iss_ready.
- Handshake:
  - Fire on port p = iss_valid[p] & iss_ready[p]. A fired entry is invalidated at the edge and its age row/column cleared.
  - An unfired entry stays resident. Its port assignment may change in later cycles if an older entry becomes ready; FUs must not assume payload stability across cycles.
- Simultaneous fire and dispatch: both apply at the same edge. A freed slot is not reused that edge.
- occupancy' = occupancy + accepted lanes - fired ports.
- flush=1: next state is all entries invalid. Dispatch and fire in that cycle are discarded; iss_valid outputs still show pre-flush state in that cycle. Flush has priority over everything except rst.
- rst mid-operation: immediate clear; no partial writes.

Test Plan:
- Reset then idle: rst pulse -> iss_valid=00, occupancy=0, disp_accept=1; ENTRIES=8 default.
- Immediate-only issue:
  - Stimulus: lane0 {aluop=0, src1 rdy=1 val=5, use_imm, imm=10, dest=3} and lane1 {src1 rdy=1 val=7, use_imm, imm=1, dest=4}; iss_ready=11.
  - Response: next cycle port0 op1=5 op2=10 dest=3, port1 op1=7 op2=1 dest=4; occupancy 2->0 following cycle.
- CDB wakeup and bypass:
  - Stimulus: entry waits on tag 6; cdb_valid[1]=1, tag=6, value=0xDEAD, in the same cycle a lane dispatches with src1 tag 6 rdy=0.
  - Response: both capture 0xDEAD; both issue the next cycle, oldest on port0.
- Age ordering under stall:
  - Stimulus: fill 8 entries; all ready; iss_ready=01 for 3 cycles.
  - Response: port0 issues entries in dispatch order; port1 valid but retained; occupancy 8->5; disp_accept 0 until occupancy<=6.
- Full backpressure: occupancy=7, DISPATCH_W=2 -> disp_accept=0, dispatch ignored, no entry written.
- Flush and reset mid-flight:
  - flush with 4 resident ops and dispatch asserted -> occupancy=0 next cycle, nothing issued after.
  - Async rst mid-cycle -> iss_valid drops immediately.
